// File: rtl/mbist_seq_ctrl_if.sv
// Memory-under-test port bundle for the MBIST sequencer.
// master = sequencer side, slave = memory wrapper side.
interface mbist_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/mbist_seq_ctrl.sv
// MBIST sequencer: runs march algorithms 1..6 on a 2**ADDR_W x DATA_W SRAM and compares read data.
// Optional MBIST_FAIL_LOG_EN keeps fail_addr/fail_count registers; otherwise both ports read 0.
module mbist_seq_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        select,
  mbist_seq_ctrl_if.master  mem,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [CNT_W-1:0]  fail_count
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  // Op encoding: {write, pattern}; pattern 0=zeros 1=ones 2=checker 3=inverse checker
  localparam logic [2:0] OP_R0  = 3'b000;
  localparam logic [2:0] OP_R1  = 3'b001;
  localparam logic [2:0] OP_RC  = 3'b010;
  localparam logic [2:0] OP_RNC = 3'b011;
  localparam logic [2:0] OP_W0  = 3'b100;
  localparam logic [2:0] OP_W1  = 3'b101;
  localparam logic [2:0] OP_WC  = 3'b110;
  localparam logic [2:0] OP_WNC = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Number of march elements per algorithm; 0 marks an unsupported code
  function automatic logic [2:0] elem_count(input logic [2:0] code);
    case (code)
      3'd1, 3'd3, 3'd4: return 3'd2;
      3'd2:             return 3'd4;
      3'd5:             return 3'd6;
      3'd6:             return 3'd3;
      default:          return 3'd0;
    endcase
  endfunction

  function automatic logic elem_down(input logic [2:0] code, input logic [2:0] idx);
    return (code == 3'd5 && (idx == 3'd3 || idx == 3'd4)) || (code == 3'd6 && idx == 3'd2);
  endfunction

  function automatic logic elem_two(input logic [2:0] code, input logic [2:0] idx);
    return (code == 3'd5 && idx >= 3'd1 && idx <= 3'd4) || (code == 3'd6 && idx != 3'd0);
  endfunction

  function automatic logic [2:0] elem_op(input logic [2:0] code, input logic [2:0] idx,
                                         input logic ph);
    logic [2:0] op;
    op = OP_R0;
    case (code)
      3'd1: op = (idx == 3'd0) ? OP_W0 : OP_R0;
      3'd2: begin
        case (idx)
          3'd0:    op = OP_W0;
          3'd1:    op = OP_R0;
          3'd2:    op = OP_W1;
          default: op = OP_R1;
        endcase
      end
      3'd3: op = (idx == 3'd0) ? OP_WC : OP_RC;
      3'd4: op = (idx == 3'd0) ? OP_WNC : OP_RNC;
      3'd5, 3'd6: begin
        if (idx == 3'd0) begin
          op = OP_W0;
        end else if (code == 3'd5 && idx == 3'd5) begin
          op = OP_R0;
        end else begin
          // (r,w) pairs alternate polarity: odd elements r0,w1 and even elements r1,w0
          op = ph ? (idx[0] ? OP_W1 : OP_W0) : (idx[0] ? OP_R0 : OP_R1);
        end
      end
      default: op = OP_R0;
    endcase
    return op;
  endfunction

  // Checkerboard is 0101.. from the LSB, inverted on odd addresses
  function automatic logic [DATA_W-1:0] pat_data(input logic [1:0] pat, input logic a0);
    logic [DATA_W-1:0] chk;
    for (int i = 0; i < int'(DATA_W); i++) begin
      chk[i] = ((i % 2) == 0) ^ a0;
    end
    case (pat)
      2'd0:    return '0;
      2'd1:    return '1;
      2'd2:    return chk;
      default: return ~chk;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        elem_q, elem_d, elem_inc;
  logic [ADDR_W-1:0] addr_q, addr_d, end_addr;
  logic              phase_q, phase_d;
  logic              issue;
  logic              launch;
  logic              sel_ok;
  logic [2:0]        op_nxt;
  logic              cmp_en;
  logic [DATA_W-1:0] cmp_exp;
  logic              mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      elem_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  // Next-state and op-pointer advance; the pointer always names the op on the bus
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    elem_d   = elem_q;
    addr_d   = addr_q;
    phase_d  = phase_q;
    issue    = 1'b0;
    launch   = 1'b0;
    elem_inc = elem_q + 3'd1;
    end_addr = elem_down(sel_q, elem_q) ? '0 : ADDR_LAST;
    sel_ok   = !select[3] && (elem_count(select[2:0]) != 3'd0);
    case (state_q)
      ST_IDLE: begin
        if (start && sel_ok) begin
          state_d = ST_RUN;
          sel_d   = select[2:0];
          elem_d  = 3'd0;
          addr_d  = '0;
          phase_d = 1'b0;
          issue   = 1'b1;
          launch  = 1'b1;
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        if (elem_two(sel_q, elem_q) && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == end_addr) begin
            if (elem_inc < elem_count(sel_q)) begin
              elem_d = elem_inc;
              addr_d = elem_down(sel_q, elem_inc) ? ADDR_LAST : '0;
            end else begin
              issue   = 1'b0;
              state_d = ST_DRAIN;
            end
          end else if (elem_down(sel_q, elem_q)) begin
            addr_d = addr_q - ADDR_W'(1);
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    op_nxt = elem_op(sel_d, elem_d, phase_d);
  end

  assign mismatch = cmp_en && (mem.mem_rdata != cmp_exp);

  // Memory strobes, status and the one-cycle compare pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_re    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      cmp_en        <= 1'b0;
      cmp_exp       <= '0;
    end else begin
      mem.mem_we <= issue & op_nxt[2];
      mem.mem_re <= issue & ~op_nxt[2];
      if (issue) begin
        mem.mem_addr  <= addr_d;
        mem.mem_wdata <= pat_data(op_nxt[1:0], addr_d[0]);
      end
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DRAIN);
      cmp_en  <= mem.mem_re;
      cmp_exp <= mem.mem_wdata;
      if (launch) begin
        fail <= 1'b0;
      end else if (mismatch) begin
        fail <= 1'b1;
      end
    end
  end

`ifdef MBIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] cmp_addr;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [CNT_W-1:0]  fail_count_q;

  // First-fail address and saturating mismatch count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_addr     <= '0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
    end else begin
      cmp_addr <= mem.mem_addr;
      if (launch) begin
        fail_addr_q  <= '0;
        fail_count_q <= '0;
      end else if (mismatch) begin
        if (!fail) begin
          fail_addr_q <= cmp_addr;
        end
        if (fail_count_q != '1) begin
          fail_count_q <= fail_count_q + CNT_W'(1);
        end
      end
    end
  end

  assign fail_addr  = fail_addr_q;
  assign fail_count = fail_count_q;
`else
  assign fail_addr  = '0;
  assign fail_count = '0;
`endif

endmodule

// File: tb/tb_mbist_seq_ctrl.sv
// Scoreboard bench for mbist_seq_ctrl: march model queues expected ops, monitor pops and compares.
module tb_mbist_seq_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
  localparam int          D  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    select;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [CW-1:0] fail_count;

  int n_tests = 0;
  int n_fail  = 0;

  mbist_seq_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mbist_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .select     (select),
    .mem        (bus),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM model with an optional stuck-at-1 on bit 0 of one address
  logic [DW-1:0] mem_arr [D];
  logic          stuck_en;
  logic [AW-1:0] stuck_addr;

  always @(posedge clk) begin
    if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re)
      bus.mem_rdata <= mem_arr[bus.mem_addr] |
                       ((stuck_en && bus.mem_addr == stuck_addr) ? 8'h01 : 8'h00);
  end

  // Expected op stream: {is_write, addr, write data (0 for reads)}
  logic [12:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat_val(input byte p, input logic [AW-1:0] a);
    case (p)
      "1":     return 8'hFF;
      "C":     return a[0] ? 8'hAA : 8'h55;
      "N":     return a[0] ? 8'h55 : 8'hAA;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_op(input string o, input logic [AW-1:0] a);
    logic is_w;
    is_w = (o[0] == "w");
    exp_q.push_back({is_w, a, is_w ? pat_val(o[1], a) : 8'h00});
  endtask

  task automatic push_elem(input bit down, input string o0, input string o1);
    logic [AW-1:0] a;
    for (int i = 0; i < D; i++) begin
      a = down ? AW'(D - 1 - i) : AW'(i);
      push_op(o0, a);
      if (o1.len() != 0) push_op(o1, a);
    end
  endtask

  task automatic build_model(input logic [3:0] code);
    case (code)
      4'd1: begin push_elem(0, "w0", ""); push_elem(0, "r0", ""); end
      4'd2: begin
        push_elem(0, "w0", ""); push_elem(0, "r0", "");
        push_elem(0, "w1", ""); push_elem(0, "r1", "");
      end
      4'd3: begin push_elem(0, "wC", ""); push_elem(0, "rC", ""); end
      4'd4: begin push_elem(0, "wN", ""); push_elem(0, "rN", ""); end
      4'd5: begin
        push_elem(0, "w0", "");
        push_elem(0, "r0", "w1"); push_elem(0, "r1", "w0");
        push_elem(1, "r0", "w1"); push_elem(1, "r1", "w0");
        push_elem(0, "r0", "");
      end
      4'd6: begin
        push_elem(0, "w0", "");
        push_elem(0, "r0", "w1"); push_elem(1, "r1", "w0");
      end
      default: ;
    endcase
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, " mem_addr"},   32'(bus.mem_addr),  0);
    check_eq({tag, " mem_wdata"},  32'(bus.mem_wdata), 0);
    check_eq({tag, " mem_we"},     32'(bus.mem_we),    0);
    check_eq({tag, " mem_re"},     32'(bus.mem_re),    0);
    check_eq({tag, " busy"},       32'(busy),          0);
    check_eq({tag, " done"},       32'(done),          0);
    check_eq({tag, " fail"},       32'(fail),          0);
    check_eq({tag, " fail_addr"},  32'(fail_addr),     0);
    check_eq({tag, " fail_count"}, 32'(fail_count),    0);
  endtask

  // Launch one algorithm and monitor it through cycle n+2; poke_cyc>0 raises start (select 2) in that cycle
  task automatic run_algo(input logic [3:0] code, input int n, input logic exp_fail,
                          input logic [AW-1:0] exp_faddr, input logic [CW-1:0] exp_fcnt,
                          input int poke_cyc);
    logic [12:0] got;
    int          ops_seen;
    ops_seen = 0;
    exp_q.delete();
    build_model(code);
    @(negedge clk);
    start  = 1'b1;
    select = code;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= n + 2; cyc++) begin
      @(negedge clk);
      if (cyc == poke_cyc) begin start = 1'b1; select = 4'd2; end
      if (cyc == poke_cyc + 1) start = 1'b0;
      check_eq($sformatf("s%0d busy c%0d", code, cyc), 32'(busy), 32'(cyc <= n + 1));
      check_eq($sformatf("s%0d done c%0d", code, cyc), 32'(done), 32'(cyc == n + 1));
      check_eq($sformatf("s%0d we_re c%0d", code, cyc), 32'(bus.mem_we & bus.mem_re), 0);
      if (bus.mem_we || bus.mem_re) begin
        ops_seen++;
        got = {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 8'h00};
        if (exp_q.size() != 0)
          check_eq($sformatf("s%0d op c%0d", code, cyc), 32'(got), 32'(exp_q.pop_front()));
      end
    end
    check_eq($sformatf("s%0d op_count", code), 32'(ops_seen), 32'(n));
    check_eq($sformatf("s%0d fail", code), 32'(fail), 32'(exp_fail));
    check_eq($sformatf("s%0d fail_addr", code), 32'(fail_addr), 32'(exp_faddr));
    check_eq($sformatf("s%0d fail_count", code), 32'(fail_count), 32'(exp_fcnt));
  endtask

  task automatic try_invalid(input logic [3:0] code);
    @(negedge clk);
    start  = 1'b1;
    select = code;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq($sformatf("bad%0d busy", code), 32'(busy), 0);
      check_eq($sformatf("bad%0d strobes", code), 32'({bus.mem_we, bus.mem_re}), 0);
    end
  endtask

  initial begin
    logic [AW-1:0] x_faddr;
    logic [CW-1:0] x_fcnt;
`ifdef MBIST_FAIL_LOG_EN
    x_faddr = 4'd7;
    x_fcnt  = 8'd3;
`else
    x_faddr = 4'd0;
    x_fcnt  = 8'd0;
`endif
    rst        = 1'b1;
    start      = 1'b0;
    select     = 4'd0;
    stuck_en   = 1'b0;
    stuck_addr = 4'd7;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;

    run_algo(4'd1, 2 * D, 1'b0, 0, 0, 0);
    run_algo(4'd3, 2 * D, 1'b0, 0, 0, 0);

    stuck_en = 1'b1;
    run_algo(4'd5, 10 * D, 1'b1, x_faddr, x_fcnt, 0);
    stuck_en = 1'b0;

    try_invalid(4'd0);
    try_invalid(4'd9);
    try_invalid(4'd7);
    check_eq("fail hold", 32'(fail), 1);
    check_eq("fail_addr hold", 32'(fail_addr), 32'(x_faddr));

    // start with a different code mid-run must not disturb the sequence
    run_algo(4'd6, 5 * D, 1'b0, 0, 0, 5);

    // start in the done cycle must be ignored
    run_algo(4'd4, 2 * D, 1'b0, 0, 0, 2 * D + 1);
    repeat (2) begin
      @(negedge clk);
      check_eq("post_done busy", 32'(busy), 0);
      check_eq("post_done strobes", 32'({bus.mem_we, bus.mem_re}), 0);
    end

    // async reset in the middle of a blanket run
    @(negedge clk);
    start  = 1'b1;
    select = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("mid busy", 32'(busy), 1);
    check_eq("mid fail_addr", 32'(fail_addr), 0);
    check_eq("mid fail_count", 32'(fail_count), 0);
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    run_algo(4'd2, 4 * D, 1'b0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
